// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants for the 28x28 drawing grid plot path
package grid_pkg;

  localparam int GRID_SIZE     = 28;
  localparam int PIXEL_SIZE    = 4;
  localparam int GRID_OFFSET_X = 10;
  localparam int GRID_OFFSET_Y = 10;

  localparam int CELL_W = 5;
  localparam int VX_W   = 8;
  localparam int VY_W   = 7;
  localparam int COL_W  = 3;
  localparam int SUB_W  = $clog2(PIXEL_SIZE);

  localparam logic [COL_W-1:0] WHITE = 3'b111;
  localparam logic [COL_W-1:0] BLACK = 3'b000;
  localparam logic [COL_W-1:0] RED   = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CELL  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  function automatic logic in_grid(input logic [CELL_W-1:0] x, input logic [CELL_W-1:0] y);
    return (int'(x) < GRID_SIZE) && (int'(y) < GRID_SIZE);
  endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// rtl/cell_scan_counter.sv - cell/sub-pixel scan counters for one cell or a full-grid sweep
module cell_scan_counter
  import grid_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [CELL_W-1:0] start_cx,
  input  logic [CELL_W-1:0] start_cy,
  output logic [CELL_W-1:0] cx,
  output logic [CELL_W-1:0] cy,
  output logic [SUB_W-1:0]  sub_x,
  output logic [SUB_W-1:0]  sub_y,
  output logic              last_pixel,
  output logic              last_cell
);

  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(PIXEL_SIZE - 1);
  localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(GRID_SIZE - 1);

  logic              active;
  logic              mode_q;
  logic              done;
  logic [CELL_W-1:0] cx_q, cy_q;
  logic [SUB_W-1:0]  sx_q, sy_q;

  // Strobes describe the pixel on screen now; cx/cy/sub_x/sub_y are the pixel shown after this edge.
  always_comb begin
    last_pixel = active && (sx_q == SUB_MAX) && (sy_q == SUB_MAX);
    last_cell  = active && (!mode_q || ((cx_q == CELL_MAX) && (cy_q == CELL_MAX)));
    done       = last_pixel && last_cell;
    cx    = cx_q;
    cy    = cy_q;
    sub_x = sx_q;
    sub_y = sy_q;
    if (start) begin
      cx    = start_cx;
      cy    = start_cy;
      sub_x = '0;
      sub_y = '0;
    end else if (active && !done) begin
      if (sx_q != SUB_MAX) begin
        sub_x = sx_q + SUB_W'(1);
      end else begin
        sub_x = '0;
        if (sy_q != SUB_MAX) begin
          sub_y = sy_q + SUB_W'(1);
        end else begin
          sub_y = '0;
          if (cx_q != CELL_MAX) begin
            cx = cx_q + CELL_W'(1);
          end else begin
            cx = '0;
            cy = cy_q + CELL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      mode_q <= 1'b0;
      cx_q   <= '0;
      cy_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
    end else begin
      cx_q <= cx;
      cy_q <= cy;
      sx_q <= sub_x;
      sy_q <= sub_y;
      if (start) begin
        active <= 1'b1;
        mode_q <= mode;
      end else if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/grid_plot_scheduler.sv
// rtl/grid_plot_scheduler.sv - arbitrates cell repaint/clear jobs onto the vga_adapter write port
module grid_plot_scheduler
  import grid_pkg::*;
#(
  parameter logic [COL_W-1:0] CLEAR_COLOUR = WHITE
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_ack,
  input  logic              a_req,
  input  logic [CELL_W-1:0] a_x,
  input  logic [CELL_W-1:0] a_y,
  input  logic [COL_W-1:0]  a_colour,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [CELL_W-1:0] b_x,
  input  logic [CELL_W-1:0] b_y,
  input  logic [COL_W-1:0]  b_colour,
  output logic              b_ack,
  output logic              busy,
  output logic [VX_W-1:0]   vga_x,
  output logic [VY_W-1:0]   vga_y,
  output logic [COL_W-1:0]  vga_colour,
  output logic              vga_plot
);

  logic [1:0]        state;
  logic              rr_last;
  logic              pick_a, pick_b, sel_in_range, start, burst_done;
  logic [CELL_W-1:0] sel_x, sel_y, start_cx, start_cy;
  logic [COL_W-1:0]  sel_colour;
  logic [CELL_W-1:0] pos_cx, pos_cy;
  logic [SUB_W-1:0]  pos_sx, pos_sy;
  logic              last_pixel, last_cell;
  logic [VX_W-1:0]   next_x;
  logic [VY_W-1:0]   next_y;

  // rr_last: 0 = A served last, 1 = B served last.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (state == ST_IDLE && !clear_req) begin
      pick_a = a_req && (!b_req || rr_last);
      pick_b = b_req && (!a_req || !rr_last);
    end
    sel_x        = pick_b ? b_x : a_x;
    sel_y        = pick_b ? b_y : a_y;
    sel_colour   = pick_b ? b_colour : a_colour;
    sel_in_range = in_grid(sel_x, sel_y);
    start        = (state == ST_IDLE) && (clear_req || ((pick_a || pick_b) && sel_in_range));
    start_cx     = clear_req ? '0 : sel_x;
    start_cy     = clear_req ? '0 : sel_y;
    burst_done   = last_pixel && last_cell;
    next_x = VX_W'(GRID_OFFSET_X + int'(pos_cx) * PIXEL_SIZE + int'(pos_sx));
    next_y = VY_W'(GRID_OFFSET_Y + int'(pos_cy) * PIXEL_SIZE + int'(pos_sy));
  end

  cell_scan_counter u_scan (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (clear_req),
    .start_cx   (start_cx),
    .start_cy   (start_cy),
    .cx         (pos_cx),
    .cy         (pos_cy),
    .sub_x      (pos_sx),
    .sub_y      (pos_sy),
    .last_pixel (last_pixel),
    .last_cell  (last_cell)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_last    <= 1'b1;
      clear_ack  <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      clear_ack <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            clear_ack  <= 1'b1;
            state      <= ST_CLEAR;
            vga_colour <= CLEAR_COLOUR;
            vga_plot   <= 1'b1;
            busy       <= 1'b1;
          end else if (pick_a || pick_b) begin
            a_ack   <= pick_a;
            b_ack   <= pick_b;
            rr_last <= pick_b;
            // Off-grid cells are acknowledged but never drawn.
            if (sel_in_range) begin
              state      <= ST_CELL;
              vga_colour <= sel_colour;
              vga_plot   <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        ST_CELL, ST_CLEAR: begin
          if (burst_done) begin
            state    <= ST_IDLE;
            vga_plot <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          vga_plot <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
      if (start || (state != ST_IDLE && !burst_done)) begin
        vga_x <= next_x;
        vga_y <= next_y;
      end
    end
  end

endmodule

// File: tb/tb_grid_plot_scheduler.sv
// tb/tb_grid_plot_scheduler.sv - self-checking bench for grid_plot_scheduler
module tb_grid_plot_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0, a_req = 1'b0, b_req = 1'b0;
  logic [4:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
  logic [2:0] a_colour = '0, b_colour = '0;
  logic       clear_ack, a_ack, b_ack, busy, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  grid_plot_scheduler dut (
    .clock(clock), .reset(reset),
    .clear_req(clear_req), .clear_ack(clear_ack),
    .a_req(a_req), .a_x(a_x), .a_y(a_y), .a_colour(a_colour), .a_ack(a_ack),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_colour(b_colour), .b_ack(b_ack),
    .busy(busy), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #10 clock = ~clock;

  typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  typedef struct {
    logic port_b; logic [4:0] x; logic [4:0] y; logic [2:0] c;
    logic plots; logic [7:0] x0; logic [6:0] y0;
  } vec_t;

  pix_t       exp_q[$];
  int         total = 0, bad = 0;
  int         cyc = 0, plot_cnt = 0;
  int         m_rr = 1;
  logic [2:0] ack_seen;
  logic [7:0] last_x;
  logic [6:0] last_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cell(input int cx, input int cy, input logic [2:0] c);
    pix_t p;
    for (int sy = 0; sy < 4; sy++)
      for (int sx = 0; sx < 4; sx++) begin
        p.x = 8'(10 + cx * 4 + sx);
        p.y = 7'(10 + cy * 4 + sy);
        p.c = c;
        exp_q.push_back(p);
      end
  endtask

  // Reference model: one call per cycle, sampled at the falling edge.
  task automatic tick();
    logic [2:0] want;
    pix_t       p;
    @(negedge clock);
    cyc++;
    ack_seen = {clear_ack, a_ack, b_ack};
    if (reset) begin
      exp_q.delete();
      m_rr = 1;
      chk("reset_acks", 32'(ack_seen), 0);
    end else if (ack_seen != 3'b000) begin
      if (clear_req)             want = 3'b100;
      else if (a_req && b_req)   want = (m_rr == 1) ? 3'b010 : 3'b001;
      else if (a_req)            want = 3'b010;
      else if (b_req)            want = 3'b001;
      else                       want = 3'b000;
      chk("grant_port", 32'(ack_seen), 32'(want));
      chk("grant_during_burst", exp_q.size(), 0);
      if (want == 3'b100) begin
        for (int cy = 0; cy < 28; cy++)
          for (int cx = 0; cx < 28; cx++) push_cell(cx, cy, 3'b111);
      end else if (want == 3'b010) begin
        m_rr = 0;
        if (a_x < 28 && a_y < 28) push_cell(int'(a_x), int'(a_y), a_colour);
      end else if (want == 3'b001) begin
        m_rr = 1;
        if (b_x < 28 && b_y < 28) push_cell(int'(b_x), int'(b_y), b_colour);
      end
    end
    chk("plot", 32'(vga_plot), 32'(exp_q.size() > 0));
    if (vga_plot && exp_q.size() > 0) begin
      p = exp_q.pop_front();
      chk("pix_x", 32'(vga_x), 32'(p.x));
      chk("pix_y", 32'(vga_y), 32'(p.y));
      chk("pix_colour", 32'(vga_colour), 32'(p.c));
      chk("plot_busy", 32'(busy), 1);
      plot_cnt++;
      last_x = vga_x;
      last_y = vga_y;
    end
  endtask

  task automatic wait_ack(input logic [2:0] which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((ack_seen & which) != 3'b000) begin
        at = cyc;
        return;
      end
    end
    chk("ack_timeout", 32'(ack_seen & which), 32'(which));
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) return;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    vec_t tbl[7];
    int   at, at2, prev;
    logic extra;

    tbl[0] = '{1'b0, 5'd3,  5'd5,  3'b100, 1'b1, 8'd22,  7'd30};
    tbl[1] = '{1'b1, 5'd0,  5'd0,  3'b010, 1'b1, 8'd10,  7'd10};
    tbl[2] = '{1'b0, 5'd27, 5'd27, 3'b001, 1'b1, 8'd118, 7'd118};
    tbl[3] = '{1'b1, 5'd28, 5'd0,  3'b011, 1'b0, 8'd0,   7'd0};
    tbl[4] = '{1'b0, 5'd12, 5'd1,  3'b011, 1'b1, 8'd58,  7'd14};
    tbl[5] = '{1'b0, 5'd5,  5'd31, 3'b101, 1'b0, 8'd0,   7'd0};
    tbl[6] = '{1'b1, 5'd27, 5'd0,  3'b110, 1'b1, 8'd118, 7'd10};

    repeat (3) tick();
    chk("rst_vga_x", 32'(vga_x), 0);
    chk("rst_vga_y", 32'(vga_y), 0);
    chk("rst_colour", 32'(vga_colour), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acks", 32'({clear_ack, a_ack, b_ack}), 0);
    reset = 1'b0;
    tick();

    // Single requests, in and out of the grid.
    for (int i = 0; i < 7; i++) begin
      plot_cnt = 0;
      if (tbl[i].port_b) begin
        b_req = 1'b1; b_x = tbl[i].x; b_y = tbl[i].y; b_colour = tbl[i].c;
      end else begin
        a_req = 1'b1; a_x = tbl[i].x; a_y = tbl[i].y; a_colour = tbl[i].c;
      end
      wait_ack(tbl[i].port_b ? 3'b001 : 3'b010, 10, at);
      chk("tbl_first_plot", 32'(vga_plot), 32'(tbl[i].plots));
      if (tbl[i].plots) begin
        chk("tbl_x0", 32'(vga_x), 32'(tbl[i].x0));
        chk("tbl_y0", 32'(vga_y), 32'(tbl[i].y0));
      end
      a_req = 1'b0;
      b_req = 1'b0;
      wait_idle(40);
      chk("tbl_plot_count", plot_cnt, tbl[i].plots ? 16 : 0);
      tick();
    end

    // A and B held together: alternate, 17 cycles apart.
    a_req = 1'b1; a_x = 5'd1; a_y = 5'd1; a_colour = 3'b010;
    b_req = 1'b1; b_x = 5'd2; b_y = 5'd3; b_colour = 3'b001;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack(3'b011, 40, at);
      chk("rr_order", 32'(ack_seen), (g % 2 == 0) ? 32'd2 : 32'd1);
      if (g > 0) chk("rr_spacing", at - prev, 17);
      prev = at;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    wait_idle(40);

    // Clear beats simultaneous A and B, then A, then B.
    clear_req = 1'b1;
    a_req = 1'b1; a_x = 5'd1; a_y = 5'd2; a_colour = 3'b100;
    b_req = 1'b1; b_x = 5'd4; b_y = 5'd6; b_colour = 3'b010;
    plot_cnt = 0;
    wait_ack(3'b111, 5, at);
    chk("clear_first_ack", 32'(ack_seen), 4);
    chk("clear_first_x", 32'(vga_x), 10);
    chk("clear_first_y", 32'(vga_y), 10);
    chk("clear_colour", 32'(vga_colour), 7);
    clear_req = 1'b0;
    wait_idle(13000);
    chk("clear_plots", plot_cnt, 12544);
    chk("clear_last_x", 32'(last_x), 121);
    chk("clear_last_y", 32'(last_y), 121);
    wait_ack(3'b011, 3, at2);
    chk("after_clear_a", 32'(ack_seen), 2);
    chk("clear_to_a", at2 - at, 12545);
    a_req = 1'b0;
    wait_ack(3'b011, 40, at);
    chk("after_a_b", 32'(ack_seen), 1);
    chk("a_to_b", at - at2, 17);
    b_req = 1'b0;
    wait_idle(40);

    // Reset at the 8th pixel of a burst, with B waiting.
    a_req = 1'b1; a_x = 5'd6; a_y = 5'd7; a_colour = 3'b001;
    wait_ack(3'b010, 10, at);
    a_req = 1'b0;
    b_req = 1'b1; b_x = 5'd2; b_y = 5'd2; b_colour = 3'b100;
    repeat (7) tick();
    chk("pixel8_x", 32'(vga_x), 37);
    chk("pixel8_y", 32'(vga_y), 39);
    reset = 1'b1;
    tick();
    chk("midrst_plot", 32'(vga_plot), 0);
    chk("midrst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    wait_ack(3'b011, 3, at);
    chk("post_rst_b", 32'(ack_seen), 1);
    b_req = 1'b0;
    wait_idle(40);

    // Inputs changing mid-burst; held request is a new job only after IDLE.
    a_req = 1'b1; a_x = 5'd7; a_y = 5'd9; a_colour = 3'b100;
    wait_ack(3'b010, 10, at);
    a_x = 5'd20; a_colour = 3'b001;
    wait_ack(3'b011, 40, at2);
    chk("held_req_spacing", at2 - at, 17);
    a_req = 1'b0;
    wait_idle(40);

    // Randomized request mix against the reference model.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(1, 3);
      extra = 1'b0;
      if (r[0]) begin
        a_req = 1'b1; a_x = 5'($urandom_range(0, 31)); a_y = 5'($urandom_range(0, 29));
        a_colour = 3'($urandom);
      end
      if (r[1]) begin
        b_req = 1'b1; b_x = 5'($urandom_range(0, 29)); b_y = 5'($urandom_range(0, 31));
        b_colour = 3'($urandom);
      end
      for (int k = 0; k < 80; k++) begin
        tick();
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
        if (!extra && busy && $urandom_range(0, 5) == 0) begin
          extra = 1'b1;
          if (!a_req) begin
            a_req = 1'b1; a_x = 5'($urandom_range(0, 27)); a_y = 5'($urandom_range(0, 27));
            a_colour = 3'($urandom);
          end else if (!b_req) begin
            b_req = 1'b1; b_x = 5'($urandom_range(0, 27)); b_y = 5'($urandom_range(0, 27));
            b_colour = 3'($urandom);
          end
        end
        if (!a_req && !b_req && !busy && exp_q.size() == 0) break;
      end
      chk("rand_pending", 32'({a_req, b_req}), 0);
      a_req = 1'b0;
      b_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
